io_bus_arbiter: RTL and testbench

Arbitrates non-cached I/O requests (`ioreq_packet_t`) from all cores onto the single shared I/O bus (`io_bus_interface`, master side) and returns each result as an `iorsp_packet_t` tagged with the originating core. It sits between the per-core I/O request queues and the peripheral register bus at the top level. Only one transaction is outstanding at a time, and grants rotate round-robin across cores.

---
 rtl/io_bus_arbiter.sv | 131 +++++++++++++
 tb/tb_io_bus_arbiter.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/io_bus_arbiter.sv
// Round-robin arbiter that funnels per-core non-cached I/O requests onto one
// shared I/O bus, one outstanding transaction at a time.
`ifndef NUM_CORES
`define NUM_CORES 4
`endif

module io_bus_arbiter #(
  parameter int NUM_REQUESTERS   = `NUM_CORES,
  parameter int THREAD_IDX_WIDTH = 2,
  parameter int CORE_ID_WIDTH    = 4,
  localparam int REQ_W = 1 + THREAD_IDX_WIDTH + 64,
  localparam int RSP_W = CORE_ID_WIDTH + THREAD_IDX_WIDTH + 32
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic [NUM_REQUESTERS-1:0]                req_valid,
  input  logic [NUM_REQUESTERS-1:0][REQ_W-1:0]     req_packet,
  output logic [NUM_REQUESTERS-1:0]                req_ready,
  output logic                                     io_bus_write_en,
  output logic                                     io_bus_read_en,
  output logic [31:0]                              io_bus_address,
  output logic [31:0]                              io_bus_write_data,
  input  logic [31:0]                              io_bus_read_data,
  output logic                                     rsp_valid,
  output logic [RSP_W-1:0]                         rsp_packet
);

  localparam int IDX_W = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1;

  typedef struct packed {
    logic                        store;
    logic [THREAD_IDX_WIDTH-1:0] thread_idx;
    logic [31:0]                 address;
    logic [31:0]                 value;
  } ioreq_t;

  typedef struct packed {
    logic [CORE_ID_WIDTH-1:0]    core;
    logic [THREAD_IDX_WIDTH-1:0] thread_idx;
    logic [31:0]                 read_value;
  } iorsp_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESPOND} state_t;

  state_t                      state;
  logic [IDX_W-1:0]            rr_ptr;
  logic [IDX_W-1:0]            grant_idx;
  logic                        grant_any;
  int unsigned                 scan_idx;
  ioreq_t                      grant_req;
  logic [IDX_W-1:0]            cur_port;
  logic                        cur_store;
  logic [THREAD_IDX_WIDTH-1:0] cur_thread;
  iorsp_t                      rsp_q;

  assign rsp_packet = rsp_q;
  assign grant_req  = ioreq_t'(req_packet[grant_idx]);

  // Scan ports starting at rr_ptr, wrapping at NUM_REQUESTERS-1.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    scan_idx  = 0;
    for (int unsigned i = 0; i < NUM_REQUESTERS; i++) begin
      scan_idx = 32'(rr_ptr) + i;
      if (scan_idx >= NUM_REQUESTERS)
        scan_idx = scan_idx - NUM_REQUESTERS;
      if (!grant_any && req_valid[IDX_W'(scan_idx)]) begin
        grant_any = 1'b1;
        grant_idx = IDX_W'(scan_idx);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (!reset && state == IDLE && grant_any)
      req_ready[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      rr_ptr            <= '0;
      cur_port          <= '0;
      cur_store         <= 1'b0;
      cur_thread        <= '0;
      io_bus_write_en   <= 1'b0;
      io_bus_read_en    <= 1'b0;
      io_bus_address    <= '0;
      io_bus_write_data <= '0;
      rsp_valid         <= 1'b0;
      rsp_q             <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            cur_port          <= grant_idx;
            cur_store         <= grant_req.store;
            cur_thread        <= grant_req.thread_idx;
            rr_ptr            <= (32'(grant_idx) == NUM_REQUESTERS - 1) ? '0 : grant_idx + 1'b1;
            // Strobes are launched from the accept edge so they appear in ISSUE.
            io_bus_write_en   <= grant_req.store;
            io_bus_read_en    <= !grant_req.store;
            io_bus_address    <= grant_req.address;
            io_bus_write_data <= grant_req.value;
            state             <= ISSUE;
          end
        end
        ISSUE: begin
          io_bus_write_en <= 1'b0;
          io_bus_read_en  <= 1'b0;
          state           <= WAIT;
        end
        WAIT: begin
          rsp_q.core       <= CORE_ID_WIDTH'(cur_port);
          rsp_q.thread_idx <= cur_thread;
          rsp_q.read_value <= cur_store ? '0 : io_bus_read_data;
          rsp_valid        <= 1'b1;
          state            <= RESPOND;
        end
        RESPOND: begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Directed self-checking bench for io_bus_arbiter with four requesters.
module tb_io_bus_arbiter;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [3:0]        req_valid = '0;
  logic [3:0][66:0]  req_packet = '0;
  logic [3:0]        req_ready;
  logic              io_bus_write_en;
  logic              io_bus_read_en;
  logic [31:0]       io_bus_address;
  logic [31:0]       io_bus_write_data;
  logic [31:0]       io_bus_read_data = 32'hBAD0BAD0;
  logic              rsp_valid;
  logic [37:0]       rsp_packet;

  logic [31:0]       rd_val = '0;
  int                errors = 0;
  int                checks = 0;
  int                dual   = 0;

  io_bus_arbiter #(.NUM_REQUESTERS(4), .THREAD_IDX_WIDTH(2), .CORE_ID_WIDTH(4)) dut (
    .clk               (clk),
    .reset             (reset),
    .req_valid         (req_valid),
    .req_packet        (req_packet),
    .req_ready         (req_ready),
    .io_bus_write_en   (io_bus_write_en),
    .io_bus_read_en    (io_bus_read_en),
    .io_bus_address    (io_bus_address),
    .io_bus_write_data (io_bus_write_data),
    .io_bus_read_data  (io_bus_read_data),
    .rsp_valid         (rsp_valid),
    .rsp_packet        (rsp_packet)
  );

  always #5 clk = ~clk;

  // Bus slave: load data is valid the cycle after read_en, garbage otherwise.
  always @(posedge clk)
    io_bus_read_data <= io_bus_read_en ? rd_val : 32'hBAD0BAD0;

  always @(negedge clk)
    if (io_bus_write_en && io_bus_read_en) dual++;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [66:0] mk(input logic st, input logic [1:0] thr,
                                     input logic [31:0] addr, input logic [31:0] val);
    return {st, thr, addr, val};
  endfunction

  task automatic txn(input string tag, input logic [3:0] mask, input logic [3:0] after,
                     input int unsigned port, input logic st, input logic [1:0] thr,
                     input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rval);
    logic [3:0] onehot;
    onehot = 4'b0001 << port;
    @(negedge clk); req_valid = mask; #1;
    check({tag, ".ready"}, req_ready, onehot);
    @(negedge clk); req_valid = after; #1;
    check({tag, ".wen"}, io_bus_write_en, st);
    check({tag, ".ren"}, io_bus_read_en, !st);
    check({tag, ".addr"}, io_bus_address, addr);
    if (st) check({tag, ".wdata"}, io_bus_write_data, wdata);
    check({tag, ".ready_busy"}, req_ready, 4'b0);
    @(negedge clk); #1;
    check({tag, ".en_off"}, {io_bus_write_en, io_bus_read_en}, 2'b00);
    check({tag, ".rsp_early"}, rsp_valid, 1'b0);
    @(negedge clk); #1;
    check({tag, ".rsp_valid"}, rsp_valid, 1'b1);
    check({tag, ".core"}, rsp_packet[37:34], 4'(port));
    check({tag, ".thread"}, rsp_packet[33:32], thr);
    check({tag, ".rval"}, rsp_packet[31:0], rval);
    check({tag, ".ready_rsp"}, req_ready, 4'b0);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst.outs", {io_bus_write_en, io_bus_read_en, rsp_valid, req_ready}, '0);
    check("rst.addr", {io_bus_address, io_bus_write_data}, '0);
    check("rst.rsp", rsp_packet, '0);
    @(negedge clk); reset = 1'b0;

    // Single load on port 2
    req_packet[2] = mk(1'b0, 2'd1, 32'hFFFF0004, 32'h0);
    rd_val = 32'hDEADBEEF;
    txn("load", 4'b0100, 4'b0000, 2, 1'b0, 2'd1, 32'hFFFF0004, 32'h0, 32'hDEADBEEF);
    @(negedge clk); #1;
    check("load.rsp_pulse", rsp_valid, 1'b0);
    check("load.rsp_hold", rsp_packet[31:0], 32'hDEADBEEF);

    // Single store on port 0
    req_packet[0] = mk(1'b1, 2'd2, 32'hFFFF0010, 32'h12345678);
    txn("store", 4'b0001, 4'b0000, 0, 1'b1, 2'd2, 32'hFFFF0010, 32'h12345678, 32'h0);

    // Full contention from reset
    for (int i = 0; i < 4; i++)
      req_packet[i] = mk(1'b0, 2'(i), 32'h100 + 32'(4 * i), 32'h0);
    rd_val = 32'hA5A50000;
    @(negedge clk); reset = 1'b1; req_valid = 4'hF; #1;
    check("cont.rst_ready", req_ready, 4'b0);
    @(negedge clk); reset = 1'b0; req_valid = 4'h0;
    for (int k = 0; k < 6; k++)
      txn($sformatf("cont%0d", k), 4'hF, (k == 5) ? 4'h0 : 4'hF, k % 4, 1'b0, 2'(k % 4),
          32'h100 + 32'(4 * (k % 4)), 32'h0, 32'hA5A50000);

    // Pointer wrap: grant port 3, then 1 and 3 compete
    req_packet[1] = mk(1'b0, 2'd3, 32'h204, 32'h0);
    req_packet[3] = mk(1'b0, 2'd2, 32'h20C, 32'h0);
    rd_val = 32'h0BADF00D;
    txn("wrap_a", 4'b1000, 4'b0000, 3, 1'b0, 2'd2, 32'h20C, 32'h0, 32'h0BADF00D);
    txn("wrap_b", 4'b1010, 4'b1000, 1, 1'b0, 2'd3, 32'h204, 32'h0, 32'h0BADF00D);
    txn("wrap_c", 4'b1000, 4'b0000, 3, 1'b0, 2'd2, 32'h20C, 32'h0, 32'h0BADF00D);

    // Reset during WAIT of a port-2 transaction
    req_packet[2] = mk(1'b0, 2'd1, 32'hFFFF0040, 32'h0);
    @(negedge clk); req_valid = 4'b0100; #1;
    check("rmid.ready", req_ready, 4'b0100);
    @(negedge clk); req_valid = 4'b0000; #1;
    check("rmid.ren", io_bus_read_en, 1'b1);
    @(negedge clk); #1;
    reset = 1'b1; req_valid = 4'hF; #1;
    check("rmid.addr", io_bus_address, 32'h0);
    check("rmid.outs", {io_bus_write_en, io_bus_read_en, rsp_valid, req_ready}, '0);
    check("rmid.rsp", rsp_packet, '0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); #1;
      check($sformatf("rmid.no_rsp%0d", c), rsp_valid, 1'b0);
    end
    reset = 1'b0; req_valid = 4'h0;
    @(negedge clk); #1;
    check("rmid.no_rsp_post", rsp_valid, 1'b0);
    req_packet[0] = mk(1'b0, 2'd0, 32'h300, 32'h0);
    req_packet[3] = mk(1'b1, 2'd3, 32'h30C, 32'hCAFE0003);
    txn("rmid.ptr0", 4'b1001, 4'b0000, 0, 1'b0, 2'd0, 32'h300, 32'h0, 32'h0BADF00D);
    txn("rmid.p3", 4'b1000, 4'b0000, 3, 1'b1, 2'd3, 32'h30C, 32'hCAFE0003, 32'h0);

    // Idle stability
    req_valid = 4'h0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk); #1;
      check($sformatf("idle%0d", c), {io_bus_write_en, io_bus_read_en, rsp_valid, req_ready}, '0);
    end

    check("no_dual_strobe", 64'(dual), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
